// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes raw switches and turns a bouncing push-button into a debounced level and a single store strobe per press.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnC,
    input  logic [3:0] sw,
    output logic       store,
    output logic       btn_level,
    output logic [3:0] sw_sync
);
    localparam int cntWidth = $clog2(DEBOUNCE_CYCLES);
    localparam logic [cntWidth-1:0] cntMax = cntWidth'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    state_t state, stateNext;
    logic [cntWidth-1:0] cnt, cntNext;
    logic btnMeta, btnS, storeNext, levelNext;
    logic [3:0] swMeta;

    always_ff @(posedge clk) begin
        if (reset) begin
            btnMeta   <= 1'b0;
            btnS      <= 1'b0;
            swMeta    <= 4'b0000;
            sw_sync   <= 4'b0000;
            state     <= IDLE;
            cnt       <= '0;
            store     <= 1'b0;
            btn_level <= 1'b0;
        end else begin
            btnMeta   <= btnC;
            btnS      <= btnMeta;
            swMeta    <= sw;
            sw_sync   <= swMeta;
            state     <= stateNext;
            cnt       <= cntNext;
            store     <= storeNext;
            btn_level <= levelNext;
        end
    end

    // Both wait states clear cnt on entry and leave at cntMax, so it never wraps.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        storeNext = 1'b0;
        case (state)
            IDLE: begin
                if (btnS) begin
                    stateNext = PRESS_WAIT;
                    cntNext   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btnS) stateNext = IDLE;
                else if (cnt == cntMax) begin
                    stateNext = PRESSED;
                    storeNext = 1'b1;
                end else cntNext = cnt + 1'b1;
            end
            PRESSED: begin
                if (!btnS) begin
                    stateNext = RELEASE_WAIT;
                    cntNext   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btnS) stateNext = PRESSED;
                else if (cnt == cntMax) stateNext = IDLE;
                else cntNext = cnt + 1'b1;
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
        levelNext = (stateNext == PRESSED) || (stateNext == RELEASE_WAIT);
    end
endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of stable clk cycles required to accept a button edge (10 ms at 100 MHz); legal range is 2 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: 100 MHz system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port btnC, input, 1 bit: raw, asynchronous, bouncing push-button.
REQ-005 The block SHALL have port sw, input, 4 bits: raw, asynchronous slide switches.
REQ-006 The block SHALL have port store, output, 1 bit: one-cycle strobe per accepted press; feeds the D/JK/T flip-flop stage.
REQ-007 The block SHALL have port btn_level, output, 1 bit: debounced button level.
REQ-008 The block SHALL have port sw_sync, output, 4 bits: synchronized switch values; feeds the D, J, K and T inputs.

Function
REQ-009 The block SHALL pass btnC through a two-flop synchronizer; the second-stage output is btn_s.
REQ-010 The block SHALL pass each sw bit through an independent two-flop synchronizer; sw_sync is the second stage and carries no debouncing.
REQ-011 The block SHALL implement an FSM with states IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus a counter cnt of width ceil(log2(DEBOUNCE_CYCLES)).
REQ-012 In IDLE, btn_s=1 SHALL move the FSM to PRESS_WAIT with cnt cleared to 0; otherwise the FSM SHALL hold.
REQ-013 In PRESS_WAIT, btn_s=0 SHALL return the FSM to IDLE (bounce rejected, no strobe).
REQ-014 In PRESS_WAIT with btn_s=1, cnt SHALL increment; when cnt==DEBOUNCE_CYCLES-1 the FSM SHALL move to PRESSED instead, so PRESS_WAIT lasts exactly DEBOUNCE_CYCLES cycles.
REQ-015 The transition PRESS_WAIT->PRESSED SHALL register store=1 for exactly one cycle; store SHALL be 0 in every other cycle.
REQ-016 In PRESSED, btn_s=0 SHALL move the FSM to RELEASE_WAIT with cnt cleared; otherwise the FSM SHALL hold, with no further strobes however long the button is held.
REQ-017 In RELEASE_WAIT, btn_s=1 SHALL return the FSM to PRESSED with no strobe; otherwise cnt SHALL increment until cnt==DEBOUNCE_CYCLES-1, at which point the FSM SHALL move to IDLE.
REQ-018 btn_level SHALL be 1 in PRESSED and RELEASE_WAIT and 0 in IDLE and PRESS_WAIT, and SHALL be a registered output.
REQ-019 Latency: with btnC stable high from before rising edge 0, store SHALL be high in the cycle following edge DEBOUNCE_CYCLES+2, and btn_level SHALL rise at the same edge.
REQ-020 The counter SHALL never wrap, because every state exit clears or bounds it.
REQ-021 An illegal FSM encoding SHALL recover to IDLE on the next clock.

Reset
REQ-022 While reset=1 at a clock edge, the FSM SHALL go to IDLE, cnt to 0, and all synchronizer flops to 0.
REQ-023 While reset=1 at a clock edge, the outputs SHALL be store=0, btn_level=0 and sw_sync=4'b0000.
REQ-024 Reset asserted mid-PRESS_WAIT or mid-PRESSED SHALL abort with no strobe.
REQ-025 After reset deasserts, a button still held SHALL be treated as a new press and SHALL produce one strobe after full debounce.

Verification (DEBOUNCE_CYCLES=4)
REQ-026 Clean press: btnC 0->1 held 20 cycles -> store high one cycle after edge 6, btn_level=1 from edge 6, exactly one strobe.
REQ-027 Bounce: btnC toggles 1,0,1,0 on consecutive cycles, then settles high -> no strobe during toggling; one strobe 7 edges after the final rise.
REQ-028 Release bounce: in PRESSED, btnC low for 2 cycles then high -> btn_level stays 1 and no second strobe; sustained low -> btn_level falls 7 edges after the fall.
REQ-029 Reset mid-operation: reset pulsed at PRESS_WAIT cnt=2 with btnC held high -> store=0 throughout reset; one strobe DEBOUNCE_CYCLES+3 edges after reset deasserts.
REQ-030 Switches: sw=4'b1010 applied -> sw_sync=4'b1010 after exactly 2 edges; reset -> sw_sync=4'b0000.
REQ-031 Repeated presses: 3 clean presses separated by 10-cycle releases -> exactly 3 single-cycle strobes.
